// File: rtl/sensor_hub_decoder_pkg.sv
// rtl/sensor_hub_decoder_pkg.sv - shared codes, frame offsets and state type for the sensor hub
// Purpose: request/status codes, byte offsets inside the 40-bit sensor frame,
//          and the decoder state enum. No ports.
package sensor_hub_pkg;

   localparam logic [7:0] REQ_STATUS      = 8'h00;
   localparam logic [7:0] REQ_TEMP_INT    = 8'h01;
   localparam logic [7:0] REQ_TEMP_FLOAT  = 8'h02;
   localparam logic [7:0] REQ_HUM_INT     = 8'h03;
   localparam logic [7:0] REQ_HUM_FLOAT   = 8'h04;
   localparam logic [7:0] REQ_STREAM_TEMP = 8'h05;
   localparam logic [7:0] REQ_STREAM_HUM  = 8'h06;
   localparam logic [7:0] REQ_STOP_A      = 8'h07;
   localparam logic [7:0] REQ_STOP_B      = 8'h08;

   localparam logic [7:0] STATUS_ERROR    = 8'h10;
   localparam logic [7:0] STATUS_OK       = 8'h11;
   localparam logic [7:0] STATUS_TIMEOUT  = 8'h12;
   localparam logic [7:0] STATUS_BAD_DEV  = 8'h13;

   localparam int HUM_INT_LSB    = 32;
   localparam int HUM_FLOAT_LSB  = 24;
   localparam int TEMP_INT_LSB   = 16;
   localparam int TEMP_FLOAT_LSB = 8;
   localparam int CHECKSUM_LSB   = 0;

   typedef enum logic [2:0] {
      IDLE,
      ACQUIRE,
      RESPOND,
      STREAM_INT,
      STREAM_FLOAT,
      STREAM_WAIT,
      FINISH
   } state_t;

endpackage

// File: rtl/sensor_hub_decoder_if.sv
// rtl/sensor_hub_decoder_if.sv - command-side interface between client and sensor hub decoder
// Purpose: groups the command request and response signals.
// Ports (modports):
//   master - client: drives enable/device_selector/request, reads the response
//   slave  - decoder: reads the command, drives requested_data/data_valid/finished/fault/busy
interface sensor_hub_decoder_if #(
   parameter int SEL_W = 2
);
   logic             enable;
   logic [SEL_W-1:0] device_selector;
   logic [7:0]       request;
   logic [7:0]       requested_data;
   logic             data_valid;
   logic             finished;
   logic             fault;
   logic             busy;

   modport master (
      output enable, device_selector, request,
      input  requested_data, data_valid, finished, fault, busy
   );

   modport slave (
      input  enable, device_selector, request,
      output requested_data, data_valid, finished, fault, busy
   );
endinterface

// File: rtl/sensor_hub_decoder_checksum.sv
// rtl/sensor_hub_decoder_checksum.sv - combinational checksum check of one 40-bit sensor frame
// Purpose: ok_o is high when the low byte equals the mod-256 sum of the four data bytes.
// Ports:
//   frame_i  in  40  frame {hum_int, hum_float, temp_int, temp_float, checksum}
//   ok_o     out  1  checksum matches
module frame_checksum_check
   import sensor_hub_pkg::*;
(
   input  logic [39:0] frame_i,
   output logic        ok_o
);
   logic [7:0] sum;

   // 8-bit sum wraps naturally, giving the mod-256 result
   assign sum  = frame_i[HUM_INT_LSB +: 8] + frame_i[HUM_FLOAT_LSB +: 8]
               + frame_i[TEMP_INT_LSB +: 8] + frame_i[TEMP_FLOAT_LSB +: 8];
   assign ok_o = (sum == frame_i[CHECKSUM_LSB +: 8]);
endmodule

// File: rtl/sensor_hub_decoder.sv
// rtl/sensor_hub_decoder.sv - multi-channel sensor arbiter serving byte requests and paced streams
// Purpose: acquires a frame from the selected sensor controller, validates it and
//          answers one byte per request, or streams int/float beats periodically.
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   cmd (slave)      command interface: enable/device_selector/request in,
//                    requested_data/data_valid/finished/fault/busy out
//   sensor_data_bus  in  40*NUM_SENSORS  per-channel frames
//   sensor_done      in  NUM_SENSORS     per-channel frame complete
//   sensor_error     in  NUM_SENSORS     per-channel protocol error
//   sensor_enable    out NUM_SENSORS     one-hot enable to the selected controller
module sensor_hub_decoder
   import sensor_hub_pkg::*;
#(
   parameter int NUM_SENSORS    = 4,
   parameter int SEL_W          = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1,
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int REFRESH_CYCLES = 100_000_000,
   parameter int CNT_W          = 27
) (
   input  logic                       clock,
   input  logic                       reset,
   sensor_hub_decoder_if.slave        cmd,
   input  logic [40*NUM_SENSORS-1:0]  sensor_data_bus,
   input  logic [NUM_SENSORS-1:0]     sensor_done,
   input  logic [NUM_SENSORS-1:0]     sensor_error,
   output logic [NUM_SENSORS-1:0]     sensor_enable
);
   localparam logic [SEL_W:0]   NUM_EXT  = (SEL_W+1)'(NUM_SENSORS);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_CYCLES - 1);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [7:0]       req_q, req_d;
   logic [39:0]      frame_q, frame_d;
   logic             err_q, err_d;
   logic             tmo_q, tmo_d;
   logic             bad_q, bad_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       data_q, data_d;
   logic             dv_q, dv_d;
   logic             fin_q, fin_d;
   logic             fault_q, fault_d;

   logic [39:0] live_frame;
   logic        chk_ok;
   logic        fail;
   logic        stream_mode;
   logic        stop_live;
   logic [7:0]  status_code;
   logic [7:0]  stream_int;
   logic [7:0]  stream_float;

   assign live_frame   = sensor_data_bus[40*int'(sel_q) +: 40];
   assign stream_mode  = (req_q == REQ_STREAM_TEMP) || (req_q == REQ_STREAM_HUM);
   assign stop_live    = (cmd.request == REQ_STOP_A) || (cmd.request == REQ_STOP_B);
   assign fail         = bad_q || tmo_q || err_q || !chk_ok;
   assign status_code  = bad_q ? STATUS_BAD_DEV : (tmo_q ? STATUS_TIMEOUT : STATUS_ERROR);
   assign stream_int   = (req_q == REQ_STREAM_TEMP) ? frame_q[TEMP_INT_LSB +: 8]
                                                    : frame_q[HUM_INT_LSB +: 8];
   assign stream_float = (req_q == REQ_STREAM_TEMP) ? frame_q[TEMP_FLOAT_LSB +: 8]
                                                    : frame_q[HUM_FLOAT_LSB +: 8];

   // Checked on the latched frame so the verdict is ready in RESPOND
   frame_checksum_check u_chk (
      .frame_i (frame_q),
      .ok_o    (chk_ok)
   );

   // The controller stays enabled through RESPOND; a bad device never gets one
   assign sensor_enable = ((state_q == ACQUIRE || state_q == RESPOND) && !bad_q)
                          ? (NUM_SENSORS'(1) << sel_q) : '0;

   assign cmd.requested_data = data_q;
   assign cmd.data_valid     = dv_q;
   assign cmd.finished       = fin_q;
   assign cmd.fault          = fault_q;
   assign cmd.busy           = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      req_d   = req_q;
      frame_d = frame_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
      bad_d   = bad_q;
      data_d  = data_q;
      dv_d    = 1'b0;
      fin_d   = 1'b0;
      fault_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd.enable) begin
               sel_d = cmd.device_selector;
               req_d = cmd.request;
               err_d = 1'b0;
               tmo_d = 1'b0;
               if ({1'b0, cmd.device_selector} >= NUM_EXT) begin
                  bad_d   = 1'b1;
                  state_d = RESPOND;
               end else begin
                  bad_d   = 1'b0;
                  state_d = ACQUIRE;
               end
            end
         end
         ACQUIRE: begin
            // stop beats a same-cycle done; done beats a same-cycle timeout
            if (stream_mode && stop_live) begin
               fin_d   = 1'b1;
               state_d = FINISH;
            end else if (sensor_done[sel_q]) begin
               frame_d = live_frame;
               err_d   = sensor_error[sel_q];
               tmo_d   = 1'b0;
               state_d = RESPOND;
            end else if (cnt_q == TMO_LAST) begin
               tmo_d   = 1'b1;
               state_d = RESPOND;
            end
         end
         RESPOND: begin
            if (fail) begin
               data_d  = status_code;
               dv_d    = 1'b1;
               fin_d   = 1'b1;
               fault_d = 1'b1;
               state_d = FINISH;
            end else begin
               dv_d    = 1'b1;
               fin_d   = 1'b1;
               state_d = FINISH;
               case (req_q)
                  REQ_STATUS:     data_d = STATUS_OK;
                  REQ_TEMP_INT:   data_d = frame_q[TEMP_INT_LSB +: 8];
                  REQ_TEMP_FLOAT: data_d = frame_q[TEMP_FLOAT_LSB +: 8];
                  REQ_HUM_INT:    data_d = frame_q[HUM_INT_LSB +: 8];
                  REQ_HUM_FLOAT:  data_d = frame_q[HUM_FLOAT_LSB +: 8];
                  REQ_STREAM_TEMP, REQ_STREAM_HUM: begin
                     data_d  = stream_int;
                     fin_d   = 1'b0;
                     state_d = STREAM_INT;
                  end
                  default:        data_d = 8'h00;
               endcase
            end
         end
         STREAM_INT: begin
            data_d  = stream_float;
            dv_d    = 1'b1;
            state_d = STREAM_FLOAT;
         end
         STREAM_FLOAT: state_d = STREAM_WAIT;
         STREAM_WAIT: begin
            if (stop_live) begin
               fin_d   = 1'b1;
               state_d = FINISH;
            end else if (cnt_q == REF_LAST) begin
               state_d = ACQUIRE;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // counters restart on every state entry
      if (state_d == state_q && (state_q == ACQUIRE || state_q == STREAM_WAIT)) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= '0;
         req_q   <= '0;
         frame_q <= '0;
         err_q   <= 1'b0;
         tmo_q   <= 1'b0;
         bad_q   <= 1'b0;
         cnt_q   <= '0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         fin_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         req_q   <= req_d;
         frame_q <= frame_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
         bad_q   <= bad_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         dv_q    <= dv_d;
         fin_q   <= fin_d;
         fault_q <= fault_d;
      end
   end
endmodule

// File: tb/tb_sensor_hub_decoder.sv
// tb/tb_sensor_hub_decoder.sv - self-checking bench for sensor_hub_decoder
module tb_sensor_hub_decoder;
   localparam int NS   = 3;
   localparam int SW   = 2;
   localparam int TMO  = 1000;
   localparam int REF  = 50;

   logic            clock;
   logic            reset;
   logic [40*NS-1:0] sensor_data_bus;
   logic [NS-1:0]   sensor_done;
   logic [NS-1:0]   sensor_error;
   logic [NS-1:0]   sensor_enable;

   int total = 0;
   int bad   = 0;

   sensor_hub_decoder_if #(.SEL_W(SW)) cmd_if ();

   sensor_hub_decoder #(
      .NUM_SENSORS    (NS),
      .SEL_W          (SW),
      .TIMEOUT_CYCLES (TMO),
      .REFRESH_CYCLES (REF),
      .CNT_W          (16)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .cmd             (cmd_if),
      .sensor_data_bus (sensor_data_bus),
      .sensor_done     (sensor_done),
      .sensor_error    (sensor_error),
      .sensor_enable   (sensor_enable)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: split the frame into bytes, sum them, then answer the request
   task automatic model(input logic [7:0] req, input logic [39:0] f, input logic err,
                        output logic [7:0] b, output logic fl);
      logic [7:0] by [5];
      int sum;
      for (int k = 0; k < 5; k++) by[k] = f[39-8*k -: 8];
      sum = by[0] + by[1] + by[2] + by[3];
      if (err || (sum % 256) != int'(by[4])) begin
         b  = 8'h10;
         fl = 1'b1;
      end else begin
         fl = 1'b0;
         case (req)
            8'h00:   b = 8'h11;
            8'h01:   b = by[2];
            8'h02:   b = by[3];
            8'h03:   b = by[0];
            8'h04:   b = by[1];
            default: b = 8'h00;
         endcase
      end
   endtask

   function automatic logic [39:0] make_frame(input bit good);
      logic [31:0] d;
      logic [7:0]  s;
      d = $urandom;
      s = d[31:24] + d[23:16] + d[15:8] + d[7:0];
      if (!good) s = s + 8'(1 + $urandom_range(0, 254));
      return {d, s};
   endfunction

   task automatic accept(input int ch, input logic [7:0] req);
      cmd_if.enable          = 1'b1;
      cmd_if.device_selector = SW'(ch);
      cmd_if.request         = req;
      tick;
      cmd_if.enable          = 1'b0;
      cmd_if.request         = 8'hA5;
   endtask

   task automatic do_txn(input int ch, input logic [7:0] req, input logic [39:0] f,
                         input logic err, input int delay);
      logic [7:0] eb;
      logic       ef;
      model(req, f, err, eb, ef);
      sensor_data_bus[40*ch +: 40] = f;
      sensor_error      = '0;
      sensor_error[ch]  = err;
      accept(ch, req);
      check("txn_busy", cmd_if.busy, 1);
      check("txn_sen", sensor_enable, 64'(1) << ch);
      repeat (delay) tick;
      sensor_done[ch] = 1'b1;
      tick;
      sensor_done = '0;
      tick;
      check("txn_fin", cmd_if.finished, 1);
      check("txn_dv", cmd_if.data_valid, 1);
      check("txn_data", cmd_if.requested_data, eb);
      check("txn_fault", cmd_if.fault, ef);
      check("txn_sen_off", sensor_enable, 0);
      tick;
      check("txn_idle", cmd_if.busy, 0);
      check("txn_fin_low", cmd_if.finished, 0);
   endtask

   task automatic stream_test(input int ch, input logic [7:0] req, input logic [39:0] f,
                              input bit stop_on_done);
      logic [7:0] bi, bf;
      int n;
      bi = (req == 8'h05) ? f[23:16] : f[39:32];
      bf = (req == 8'h05) ? f[15:8]  : f[31:24];
      sensor_data_bus[40*ch +: 40] = f;
      sensor_error = '0;
      accept(ch, req);
      cmd_if.request = 8'h00;
      repeat (4) tick;
      sensor_done[ch] = 1'b1;
      tick;
      sensor_done = '0;
      tick;
      check("st_beat1_dv", cmd_if.data_valid, 1);
      check("st_beat1", cmd_if.requested_data, bi);
      check("st_beat1_fin", cmd_if.finished, 0);
      tick;
      check("st_beat2_dv", cmd_if.data_valid, 1);
      check("st_beat2", cmd_if.requested_data, bf);
      tick;
      check("st_wait_dv", cmd_if.data_valid, 0);
      n = 0;
      while (sensor_enable == '0 && n < 200) begin
         n++;
         tick;
      end
      check("st_gap", n, REF);
      check("st_reacq_sen", sensor_enable, 64'(1) << ch);
      if (!stop_on_done) begin
         repeat (3) tick;
         sensor_done[ch] = 1'b1;
         tick;
         sensor_done = '0;
         tick;
         check("st2_beat1", cmd_if.requested_data, bi);
         check("st2_beat1_dv", cmd_if.data_valid, 1);
         tick;
         check("st2_beat2", cmd_if.requested_data, bf);
         repeat (6) tick;
         cmd_if.request = 8'h07;
      end else begin
         tick;
         sensor_done[ch] = 1'b1;
         cmd_if.request  = 8'h08;
      end
      tick;
      sensor_done    = '0;
      cmd_if.request = 8'h00;
      check("st_stop_fin", cmd_if.finished, 1);
      check("st_stop_dv", cmd_if.data_valid, 0);
      check("st_stop_fault", cmd_if.fault, 0);
      tick;
      check("st_stop_busy", cmd_if.busy, 0);
   endtask

   initial begin
      logic [39:0] f;
      logic [7:0]  req;
      int          n, r;

      reset                  = 1'b1;
      cmd_if.enable          = 1'b0;
      cmd_if.device_selector = '0;
      cmd_if.request         = 8'h00;
      sensor_data_bus        = '0;
      sensor_done            = '0;
      sensor_error           = '0;
      repeat (3) tick;
      check("rst_data", cmd_if.requested_data, 0);
      check("rst_dv", cmd_if.data_valid, 0);
      check("rst_fin", cmd_if.finished, 0);
      check("rst_fault", cmd_if.fault, 0);
      check("rst_busy", cmd_if.busy, 0);
      check("rst_sen", sensor_enable, 0);
      reset = 1'b0;
      tick;

      do_txn(2, 8'h01, 40'h3700190555, 1'b0, 100);
      do_txn(0, 8'h00, 40'h3700190556, 1'b0, 5);
      do_txn(1, 8'h02, make_frame(1), 1'b1, 3);

      for (int i = 0; i < 24; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 4)      req = 8'(r);
         else if (r == 5) req = 8'h07;
         else if (r == 6) req = 8'h08;
         else             req = 8'($urandom_range(9, 255));
         f = make_frame($urandom_range(0, 9) < 7);
         do_txn($urandom_range(0, NS-1), req, f, ($urandom_range(0, 7) == 0), $urandom_range(1, 30));
      end

      // timeout on ch1
      accept(1, 8'h03);
      n = 0;
      while (!cmd_if.finished && n < 1200) begin
         tick;
         n++;
      end
      check("tmo_latency", n, TMO + 1);
      check("tmo_data", cmd_if.requested_data, 8'h12);
      check("tmo_fault", cmd_if.fault, 1);
      check("tmo_sen", sensor_enable, 0);
      tick;

      // done on the very cycle the timeout would fire wins
      f = make_frame(1);
      sensor_data_bus[0 +: 40] = f;
      accept(0, 8'h04);
      repeat (TMO - 1) tick;
      sensor_done[0] = 1'b1;
      tick;
      sensor_done = '0;
      tick;
      check("tmo_edge_fin", cmd_if.finished, 1);
      check("tmo_edge_data", cmd_if.requested_data, f[31:24]);
      check("tmo_edge_fault", cmd_if.fault, 0);
      tick;

      // bad device
      accept(3, 8'h02);
      check("bad_sen0", sensor_enable, 0);
      tick;
      check("bad_sen1", sensor_enable, 0);
      check("bad_fin", cmd_if.finished, 1);
      check("bad_data", cmd_if.requested_data, 8'h13);
      check("bad_fault", cmd_if.fault, 1);
      tick;

      // streaming
      stream_test(2, 8'h05, 40'h3700190555, 1'b0);
      stream_test(0, 8'h06, make_frame(1), 1'b1);
      do_txn(1, 8'h06, make_frame(0), 1'b0, 4);

      // enable while busy is ignored
      f = make_frame(1);
      sensor_data_bus[0 +: 40] = f;
      sensor_error = '0;
      accept(0, 8'h01);
      cmd_if.enable          = 1'b1;
      cmd_if.device_selector = 2'd2;
      cmd_if.request         = 8'h03;
      tick;
      cmd_if.enable = 1'b0;
      check("ign_sen", sensor_enable, 3'b001);
      sensor_done[0] = 1'b1;
      tick;
      sensor_done = '0;
      tick;
      check("ign_data", cmd_if.requested_data, f[23:16]);
      check("ign_fin", cmd_if.finished, 1);
      tick;

      // reset mid-acquire
      accept(1, 8'h01);
      repeat (3) tick;
      check("mid_sen", sensor_enable, 3'b010);
      reset = 1'b1;
      tick;
      check("mid_rst_sen", sensor_enable, 0);
      check("mid_rst_busy", cmd_if.busy, 0);
      check("mid_rst_data", cmd_if.requested_data, 0);
      check("mid_rst_dv", cmd_if.data_valid, 0);
      check("mid_rst_fin", cmd_if.finished, 0);
      check("mid_rst_fault", cmd_if.fault, 0);
      reset = 1'b0;
      tick;
      check("post_rst_busy", cmd_if.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sensor_hub_decoder.md
Name: sensor_hub_decoder

Overview:
Multi-channel successor to the single-DHT11 sensor facade. It arbitrates up to NUM_SENSORS external single-wire sensor controllers, each of which delivers a 40-bit frame plus done/error flags. The block serves byte requests from the command client and validates the frame checksum correctly. New over the previous generation: acquisition timeout, a fault flag, bad-device detection, and a paced streaming mode that re-acquires periodically. It sits between the command/UART client and the per-sensor controller instances.

Parameters:
NUM_SENSORS, 4, number of sensor channels (1..32)
SEL_W, $clog2(NUM_SENSORS) min 1, width of the device index
TIMEOUT_CYCLES, 50_000_000, maximum cycles to wait for sensor_done (1 s at 50 MHz)
REFRESH_CYCLES, 100_000_000, idle gap between stream acquisitions (2 s; DHT11 minimum)
CNT_W, 27, counter width; must hold max(TIMEOUT_CYCLES, REFRESH_CYCLES)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  start pulse; sampled only in IDLE
device_selector  in  SEL_W  channel index; latched on accepted enable
request  in  8  command code; latched on accepted enable; also sampled live in stream states
sensor_data_bus  in  40*NUM_SENSORS  frames; channel k occupies [40k+39:40k]
sensor_done  in  NUM_SENSORS  per-channel frame-complete level
sensor_error  in  NUM_SENSORS  per-channel protocol error, valid with done
sensor_enable  out  NUM_SENSORS  one-hot enable to the selected controller
requested_data  out  8  response byte
data_valid  out  1  one-cycle strobe; requested_data is valid
finished  out  1  one-cycle strobe; transaction complete
fault  out  1  set together with finished/data_valid when the acquisition failed
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, latched frame 0. Reset mid-transaction drops sensor_enable on the same edge.
- Frame layout: [39:32] hum_int, [31:24] hum_float, [23:16] temp_int, [15:8] temp_float, [7:0] checksum.
- Checksum OK when checksum == (hum_int + hum_float + temp_int + temp_float) mod 256.
- Request codes:
  - 00: status.
  - 01/02: temp int/float.
  - 03/04: hum int/float.
  - 05/06: stream temp/hum.
  - 07/08: stop stream.
  - Any other code: reply 0x00 with no fault.
- Status codes: 0x11 OK, 0x10 sensor error or bad checksum, 0x12 timeout, 0x13 bad device.
- States: IDLE, ACQUIRE, RESPOND, STREAM_INT, STREAM_FLOAT, STREAM_WAIT, FINISH.
- IDLE:
  - enable=1 latches sel and req.
  - If sel >= NUM_SENSORS, go to RESPOND with status 0x13 and fault=1; no sensor is enabled.
  - Otherwise go to ACQUIRE.
  - enable while busy is ignored.
- ACQUIRE:
  - sensor_enable[sel]=1; the timeout counter increments.
  - When sensor_done[sel]=1: capture the frame, evaluate error and checksum, go to RESPOND.
  - When the counter reaches TIMEOUT_CYCLES-1 without done: timeout, go to RESPOND. Done on the same cycle as the timeout wins.
- RESPOND (one cycle):
  - Registers requested_data, data_valid=1 and finished=1, visible in the following FINISH cycle.
  - On failure, requested_data = status code and fault=1, for any request.
  - Request 00 on success returns 0x11.
  - Requests 05/06 on success do not finish; they go to STREAM_INT instead.
- FINISH: deassert the strobes and sensor_enable, return to IDLE. Latency from done seen to finished high is 2 cycles.
- Streaming:
  - STREAM_INT: data_valid=1, int byte.
  - STREAM_FLOAT: data_valid=1, float byte.
  - STREAM_WAIT: sensor_enable=0; count REFRESH_CYCLES, then ACQUIRE, keeping the stream mode.
  - Acquisition failure in stream: finished=1, fault=1, status byte, then exit.
  - Live request 07/08 seen in STREAM_WAIT or stream ACQUIRE: go to FINISH with finished=1 and data_valid=0 on the next cycle.
  - Stop takes priority over a same-cycle done.
- Counter wrap: none; counters clear on every state entry.

Decomposition:
- Package sensor_hub_pkg: request codes, status codes, frame byte offset constants, state enum.
- Sub-module frame_checksum_check: 40-bit frame in, ok out, combinational.

Test Plan:
- ch2, req 01, frame 0x3700190555, done after 100 cycles -> sensor_enable=0b0100; 2 cycles later data_valid/finished=1, data=0x19, fault=0.
- ch0, req 00, frame 0x3700190556 (bad sum) -> data=0x10, fault=1.
- ch1, req 03, done never asserted, TIMEOUT_CYCLES=1000 -> finished at cycle 1002, data=0x12, fault=1, sensor_enable cleared.
- NUM_SENSORS=3, sel=3, req 02 -> no sensor_enable pulse, data=0x13, fault=1 within 3 cycles.
- req 05, frame 0x3700190555, REFRESH_CYCLES=50 -> beats 0x19 then 0x05, a 50-cycle gap, a second acquisition; request=07 during the gap -> finished=1, busy=0.
- Reset asserted mid-ACQUIRE and a second enable while busy -> all outputs 0 next cycle; the second enable is ignored.
